// File: rtl/nsdp_error_capture.sv
// First-error capture, packet counters and Ethernet activity timer for the NSDP checker.
// Every output is a flop so the register-reporting slave can sample it at any time.
module nsdp_error_capture #(
    parameter int unsigned ACT_TIMEOUT = 250000000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         clear_counters,
    input  logic         eth_beat,
    input  logic         pkt_done,
    input  logic         pkt_malformed,
    input  logic         chk_valid,
    input  logic [31:0]  chk_error,
    input  logic [511:0] chk_data,
    input  logic [31:0]  chk_exp_fdata,
    input  logic [63:0]  chk_exp_taddr,
    input  logic [31:0]  chk_exp_fc,
    input  logic [15:0]  chk_exp_seq,
    output logic         run_status,
    output logic [31:0]  error,
    output logic [511:0] error_data,
    output logic [31:0]  expected_fdata,
    output logic [63:0]  expected_taddr,
    output logic [31:0]  expected_fc,
    output logic [15:0]  expected_seq,
    output logic [63:0]  packets_rcvd,
    output logic [63:0]  malformed_packets,
    output logic         eth_active
);

    localparam logic [31:0] ACT_LOAD = 32'(ACT_TIMEOUT);

    typedef enum logic [0:0] {
        ARMED   = 1'b0,
        TRIPPED = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic        capture;
    logic [31:0] timer_q, timer_d;

    // ---------------------------------------------------------------
    // Capture FSM
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) state_q <= ARMED;
        else       state_q <= state_d;
    end

    // A failing beat coincident with clear is dropped: clear always wins.
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        case (state_q)
            ARMED: begin
                if (chk_valid && (chk_error != 32'd0) && !clear) begin
                    capture = 1'b1;
                    state_d = TRIPPED;
                end
            end
            TRIPPED: state_d = TRIPPED;
            default: state_d = ARMED;
        endcase
        if (clear) state_d = ARMED;
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            run_status     <= 1'b1;
            error          <= '0;
            error_data     <= '0;
            expected_fdata <= '0;
            expected_taddr <= '0;
            expected_fc    <= '0;
            expected_seq   <= '0;
        end else if (capture) begin
            run_status     <= 1'b0;
            error          <= chk_error;
            error_data     <= chk_data;
            expected_fdata <= chk_exp_fdata;
            expected_taddr <= chk_exp_taddr;
            expected_fc    <= chk_exp_fc;
            expected_seq   <= chk_exp_seq;
        end
    end

    // ---------------------------------------------------------------
    // Packet counters (count in both states, wrap naturally)
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset || clear_counters) begin
            packets_rcvd      <= '0;
            malformed_packets <= '0;
        end else begin
            if (pkt_done)      packets_rcvd      <= packets_rcvd + 64'd1;
            if (pkt_malformed) malformed_packets <= malformed_packets + 64'd1;
        end
    end

    // ---------------------------------------------------------------
    // Activity timer; eth_active tracks the next timer value so it
    // rises the edge after a beat and falls as the timer reaches 0.
    // ---------------------------------------------------------------
    always_comb begin
        timer_d = timer_q;
        if (eth_beat)              timer_d = ACT_LOAD;
        else if (timer_q != 32'd0) timer_d = timer_q - 32'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            timer_q    <= '0;
            eth_active <= 1'b0;
        end else begin
            timer_q    <= timer_d;
            eth_active <= (timer_d != 32'd0);
        end
    end

endmodule

// File: tb/tb_nsdp_error_capture.sv
// Scoreboard bench: stimulus queues expected output values for a given cycle,
// a negedge monitor pops and compares them against the DUT.
module tb_nsdp_error_capture;

    localparam int unsigned ACT = 16;

    logic         clk = 1'b0;
    logic         reset, clear, clear_counters, eth_beat, pkt_done, pkt_malformed, chk_valid;
    logic [31:0]  chk_error, chk_exp_fdata, chk_exp_fc;
    logic [511:0] chk_data;
    logic [63:0]  chk_exp_taddr;
    logic [15:0]  chk_exp_seq;
    logic         run_status, eth_active;
    logic [31:0]  error, expected_fdata, expected_fc;
    logic [511:0] error_data;
    logic [63:0]  expected_taddr, packets_rcvd, malformed_packets;
    logic [15:0]  expected_seq;

    nsdp_error_capture #(.ACT_TIMEOUT(ACT)) dut (
        .clk(clk), .reset(reset), .clear(clear), .clear_counters(clear_counters),
        .eth_beat(eth_beat), .pkt_done(pkt_done), .pkt_malformed(pkt_malformed),
        .chk_valid(chk_valid), .chk_error(chk_error), .chk_data(chk_data),
        .chk_exp_fdata(chk_exp_fdata), .chk_exp_taddr(chk_exp_taddr),
        .chk_exp_fc(chk_exp_fc), .chk_exp_seq(chk_exp_seq),
        .run_status(run_status), .error(error), .error_data(error_data),
        .expected_fdata(expected_fdata), .expected_taddr(expected_taddr),
        .expected_fc(expected_fc), .expected_seq(expected_seq),
        .packets_rcvd(packets_rcvd), .malformed_packets(malformed_packets),
        .eth_active(eth_active)
    );

    always #5 clk = ~clk;

    typedef enum int {K_RUN, K_ERR, K_DATA, K_FDATA, K_TADDR, K_FC, K_SEQ, K_PKT, K_MAL, K_ACT} kind_e;
    typedef struct {
        int unsigned  cyc;
        kind_e        kind;
        logic [511:0] val;
        string        name;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    always @(posedge clk) cyc++;

    function automatic logic [511:0] observe(kind_e k);
        case (k)
            K_RUN:   return 512'(run_status);
            K_ERR:   return 512'(error);
            K_DATA:  return error_data;
            K_FDATA: return 512'(expected_fdata);
            K_TADDR: return 512'(expected_taddr);
            K_FC:    return 512'(expected_fc);
            K_SEQ:   return 512'(expected_seq);
            K_PKT:   return 512'(packets_rcvd);
            K_MAL:   return 512'(malformed_packets);
            default: return 512'(eth_active);
        endcase
    endfunction

    // Monitor: compare every entry due this cycle; anything overdue is a miss.
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc <= cyc) begin
                logic [511:0] got;
                got = observe(sb[i].kind);
                n_checks++;
                if (sb[i].cyc < cyc) begin
                    n_fail++;
                    $display("FAIL %s overdue cyc=%0d now=%0d", sb[i].name, sb[i].cyc, cyc);
                end else if (got !== sb[i].val) begin
                    n_fail++;
                    $display("FAIL %s cyc=%0d got=%0h want=%0h", sb[i].name, cyc, got, sb[i].val);
                end
                sb.delete(i);
            end
        end
    end

    task automatic expect_at(input int unsigned at, input kind_e k, input logic [511:0] v, input string nm);
        exp_t e;
        e.cyc = at; e.kind = k; e.val = v; e.name = nm;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        clear = 0; clear_counters = 0; eth_beat = 0; pkt_done = 0; pkt_malformed = 0;
        chk_valid = 0; chk_error = '0; chk_data = '0;
        chk_exp_fdata = '0; chk_exp_taddr = '0; chk_exp_fc = '0; chk_exp_seq = '0;
    endtask

    logic [511:0] pat_a5, pat_3c;
    int unsigned  t0;

    initial begin
        pat_a5 = {64{8'hA5}};
        pat_3c = {64{8'h3C}};
        idle_inputs();
        reset = 1;

        // Reset state
        step();
        expect_at(cyc + 1, K_RUN,   512'd1, "rst_run");
        expect_at(cyc + 1, K_ERR,   512'd0, "rst_err");
        expect_at(cyc + 1, K_DATA,  512'd0, "rst_data");
        expect_at(cyc + 1, K_TADDR, 512'd0, "rst_taddr");
        expect_at(cyc + 1, K_PKT,   512'd0, "rst_pkt");
        expect_at(cyc + 1, K_MAL,   512'd0, "rst_mal");
        expect_at(cyc + 1, K_ACT,   512'd0, "rst_act");
        step();
        reset = 0;

        // 1: passing beats change nothing
        for (int i = 0; i < 10; i++) begin
            step();
            chk_valid = 1; chk_error = '0;
            chk_data = {16{$urandom}};
            chk_exp_seq = 16'(i);
        end
        step();
        idle_inputs();
        expect_at(cyc, K_RUN,  512'd1, "pass_run");
        expect_at(cyc, K_ERR,  512'd0, "pass_err");
        expect_at(cyc, K_DATA, 512'd0, "pass_data");
        expect_at(cyc, K_SEQ,  512'd0, "pass_seq");

        // Failing bits without chk_valid are ignored
        chk_error = 32'h8;
        expect_at(cyc + 1, K_RUN, 512'd1, "novalid_run");
        step();
        idle_inputs();

        // 2: first failing beat captured with one-cycle latency
        chk_valid = 1; chk_error = 32'h10; chk_data = pat_a5;
        chk_exp_fdata = 32'hDEADBEEF; chk_exp_taddr = 64'h0123_4567_89AB_CDEF;
        chk_exp_fc = 32'h0000_1234; chk_exp_seq = 16'h0042;
        expect_at(cyc, K_RUN, 512'd1, "cap_pre_run");
        expect_at(cyc + 1, K_RUN,   512'd0, "cap_run");
        expect_at(cyc + 1, K_ERR,   512'h10, "cap_err");
        expect_at(cyc + 1, K_DATA,  pat_a5, "cap_data");
        expect_at(cyc + 1, K_FDATA, 512'hDEADBEEF, "cap_fdata");
        expect_at(cyc + 1, K_TADDR, 512'h0123_4567_89AB_CDEF, "cap_taddr");
        expect_at(cyc + 1, K_FC,    512'h1234, "cap_fc");
        expect_at(cyc + 1, K_SEQ,   512'h42, "cap_seq");
        step();

        // 3: second failing beat leaves the snapshot frozen
        chk_error = 32'h0002_0000; chk_data = pat_3c;
        chk_exp_fdata = 32'h1111_1111; chk_exp_seq = 16'h0099;
        expect_at(cyc + 1, K_RUN,   512'd0, "frz_run");
        expect_at(cyc + 1, K_ERR,   512'h10, "frz_err");
        expect_at(cyc + 1, K_DATA,  pat_a5, "frz_data");
        expect_at(cyc + 2, K_FDATA, 512'hDEADBEEF, "frz_fdata");
        expect_at(cyc + 2, K_SEQ,   512'h42, "frz_seq");
        step();
        step();

        // 4: clear beats a coincident failing beat
        chk_valid = 1; chk_error = 32'h1; chk_data = pat_3c; chk_exp_seq = 16'h0077;
        clear = 1;
        expect_at(cyc + 1, K_RUN,   512'd1, "clr_run");
        expect_at(cyc + 1, K_ERR,   512'd0, "clr_err");
        expect_at(cyc + 1, K_DATA,  512'd0, "clr_data");
        expect_at(cyc + 1, K_FDATA, 512'd0, "clr_fdata");
        expect_at(cyc + 1, K_SEQ,   512'd0, "clr_seq");
        step();
        idle_inputs();
        expect_at(cyc + 1, K_RUN, 512'd1, "clr_hold_run");
        step();

        // Re-armed capture works again
        chk_valid = 1; chk_error = 32'h4; chk_exp_fc = 32'hCAFE_0001;
        expect_at(cyc + 1, K_ERR, 512'h4, "rearm_err");
        expect_at(cyc + 1, K_FC,  512'hCAFE_0001, "rearm_fc");
        step();
        idle_inputs();
        clear = 1;
        step();
        clear = 0;

        // 5: counters
        for (int i = 0; i < 1000; i++) begin
            step();
            pkt_done = 1;
            pkt_malformed = (i == 5 || i == 400 || i == 999);
            if (i == 499) begin
                expect_at(cyc + 1, K_PKT, 512'd500, "cnt_mid_pkt");
                expect_at(cyc + 1, K_MAL, 512'd2, "cnt_mid_mal");
            end
        end
        step();
        pkt_done = 0; pkt_malformed = 0;
        expect_at(cyc, K_PKT, 512'd1000, "cnt_pkt");
        expect_at(cyc, K_MAL, 512'd3, "cnt_mal");
        clear = 1;
        expect_at(cyc + 1, K_PKT, 512'd1000, "cnt_clr_keep_pkt");
        expect_at(cyc + 1, K_MAL, 512'd3, "cnt_clr_keep_mal");
        step();
        clear = 0; clear_counters = 1; pkt_done = 1; pkt_malformed = 1;
        expect_at(cyc + 1, K_PKT, 512'd0, "cnt_zero_pkt");
        expect_at(cyc + 1, K_MAL, 512'd0, "cnt_zero_mal");
        step();
        clear_counters = 0; pkt_done = 1; pkt_malformed = 0;
        expect_at(cyc + 1, K_PKT, 512'd1, "cnt_after_pkt");
        step();
        pkt_done = 0;

        // 6a: single beat -> active for exactly ACT cycles
        step();
        eth_beat = 1;
        t0 = cyc + 1;
        expect_at(t0 - 1,   K_ACT, 512'd0, "act_pre");
        expect_at(t0,       K_ACT, 512'd1, "act_rise");
        expect_at(t0 + ACT - 1, K_ACT, 512'd1, "act_last");
        expect_at(t0 + ACT, K_ACT, 512'd0, "act_fall");
        step();
        eth_beat = 0;
        repeat (ACT + 4) step();

        // 6b: second beat 10 cycles later pushes the fall out
        eth_beat = 1;
        t0 = cyc + 1;
        expect_at(t0 + ACT,      K_ACT, 512'd1, "act2_ext");
        expect_at(t0 + 10 + ACT - 1, K_ACT, 512'd1, "act2_last");
        expect_at(t0 + 10 + ACT, K_ACT, 512'd0, "act2_fall");
        step();
        eth_beat = 0;
        repeat (9) step();
        eth_beat = 1;
        step();
        eth_beat = 0;
        repeat (ACT + 6) step();

        foreach (sb[i]) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s never checked cyc=%0d", sb[i].name, sb[i].cyc);
        end
        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
